// File: rtl/kamacore_pkg.sv
// Shared types and widths for the kamacore fetch stage.
package kamacore_pkg;

  localparam int ADDR_WIDTH = 10;
  localparam int CPU_WIDTH  = 32;
  localparam int FIFO_WIDTH = ADDR_WIDTH + CPU_WIDTH;

  typedef enum logic [1:0] {
    BOOT   = 2'd0,
    RUN    = 2'd1,
    HALTED = 2'd2
  } fetch_state_t;

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] pc;
    logic [CPU_WIDTH-1:0]  word;
  } fetch_entry_t;

  // Next sequential word address; wraps naturally at 2^ADDR_WIDTH.
  function automatic logic [ADDR_WIDTH-1:0] pc_incr(input logic [ADDR_WIDTH-1:0] pc);
    return pc + {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
  endfunction

endpackage

// File: rtl/kamacore_fetch_fifo.sv
// Two-entry FIFO holding fetched {pc, word} pairs; flush empties it in one cycle.
module kamacore_fetch_fifo
  import kamacore_pkg::*;
#(
  parameter int WIDTH = FIFO_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic [1:0]       count
);

  logic [WIDTH-1:0] mem_r [2];
  logic             wr_ptr_r;
  logic             rd_ptr_r;
  logic [1:0]       count_r;
  logic             do_push_s;
  logic             do_pop_s;

  // Qualify requests: a push into a full FIFO is only legal alongside a pop.
  always_comb begin
    do_pop_s  = pop && (count_r != 2'd0);
    do_push_s = push && ((count_r != 2'd2) || do_pop_s);
  end

  // Storage, pointers and occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        mem_r[i] <= {WIDTH{1'b0}};
      end
      wr_ptr_r <= 1'b0;
      rd_ptr_r <= 1'b0;
      count_r  <= 2'd0;
    end else if (flush) begin
      wr_ptr_r <= 1'b0;
      rd_ptr_r <= 1'b0;
      count_r  <= 2'd0;
    end else begin
      if (do_push_s) begin
        mem_r[wr_ptr_r] <= wdata;
        wr_ptr_r        <= ~wr_ptr_r;
      end
      if (do_pop_s) begin
        rd_ptr_r <= ~rd_ptr_r;
      end
      case ({do_push_s, do_pop_s})
        2'b10:   count_r <= count_r + 2'd1;
        2'b01:   count_r <= count_r - 2'd1;
        default: count_r <= count_r;
      endcase
    end
  end

  assign rdata = mem_r[rd_ptr_r];
  assign count = count_r;

endmodule

// File: rtl/kamacore_fetch.sv
// Instruction fetch stage: sequential PC, 2-deep decoupling buffer, redirect and halt.
module kamacore_fetch
  import kamacore_pkg::*;
#(
  parameter logic [ADDR_WIDTH-1:0] RESET_PC = {ADDR_WIDTH{1'b0}}
) (
  input  logic                  clk,
  input  logic                  rst_n,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  input  logic [CPU_WIDTH-1:0]  imem_rdata,
  output logic                  instr_valid,
  input  logic                  instr_ready,
  output logic [CPU_WIDTH-1:0]  instr_data,
  output logic [ADDR_WIDTH-1:0] instr_pc,
  input  logic                  redirect_valid,
  input  logic [ADDR_WIDTH-1:0] redirect_pc,
  input  logic                  halt,
  output logic                  halted
);

  fetch_state_t          state_r;
  logic [ADDR_WIDTH-1:0] pc_r;
  logic                  halted_r;
  logic                  push_s;
  logic                  pop_s;
  logic                  flush_s;
  logic [1:0]            count_s;
  fetch_entry_t          wentry_s;
  logic [FIFO_WIDTH-1:0] head_bits_s;
  fetch_entry_t          head_s;

  assign wentry_s = '{pc: pc_r, word: imem_rdata};
  assign head_s   = fetch_entry_t'(head_bits_s);

  // Buffer control; redirect outranks halt, and the FIFO flush outranks a same-cycle pop.
  always_comb begin
    push_s  = 1'b0;
    flush_s = 1'b0;
    pop_s   = instr_valid && instr_ready;
    case (state_r)
      BOOT: begin
        push_s  = 1'b0;
        flush_s = 1'b0;
      end
      RUN: begin
        if (redirect_valid) begin
          flush_s = 1'b1;
        end else if (halt) begin
          push_s = 1'b0;
        end else begin
          push_s = (count_s != 2'd2) || pop_s;
        end
      end
      HALTED: begin
        if (redirect_valid) begin
          flush_s = 1'b1;
        end else begin
          flush_s = 1'b0;
        end
      end
      default: begin
        push_s  = 1'b0;
        flush_s = 1'b0;
      end
    endcase
  end

  // State, PC and the registered halted flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r  <= BOOT;
      pc_r     <= RESET_PC;
      halted_r <= 1'b0;
    end else begin
      case (state_r)
        BOOT: begin
          state_r  <= RUN;
          halted_r <= 1'b0;
        end
        RUN: begin
          if (redirect_valid) begin
            pc_r     <= redirect_pc;
            state_r  <= RUN;
            halted_r <= 1'b0;
          end else if (halt) begin
            state_r  <= HALTED;
            halted_r <= 1'b1;
          end else if (push_s) begin
            pc_r <= pc_incr(pc_r);
          end else begin
            pc_r <= pc_r;
          end
        end
        HALTED: begin
          if (redirect_valid) begin
            pc_r     <= redirect_pc;
            state_r  <= RUN;
            halted_r <= 1'b0;
          end else begin
            halted_r <= 1'b1;
          end
        end
        default: begin
          state_r  <= BOOT;
          halted_r <= 1'b0;
        end
      endcase
    end
  end

  kamacore_fetch_fifo #(
    .WIDTH(FIFO_WIDTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push_s),
    .pop   (pop_s),
    .flush (flush_s),
    .wdata (wentry_s),
    .rdata (head_bits_s),
    .count (count_s)
  );

  assign imem_addr   = pc_r;
  assign instr_valid = (count_s != 2'd0);
  assign instr_data  = head_s.word;
  assign instr_pc    = head_s.pc;
  assign halted      = halted_r;

endmodule
